// File: rtl/exp_encoder325_seq_pkg.sv
// Shared constants, FSM state type and popcount helper for the pending-request encoder.
package enc_pkg;

    localparam int REQ_W = 32;
    localparam int IDX_W = 5;
    localparam int CNT_W = 6;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    function automatic logic [CNT_W-1:0] popcount(input logic [REQ_W-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < REQ_W; i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/exp_encoder325_seq_if.sv
// Request/present/accept bundle between the request producer and the encoder.
interface exp_encoder325_seq_if;
    import enc_pkg::*;

    logic [REQ_W-1:0] Din;
    logic             En;
    logic             Ready;
    logic [IDX_W-1:0] Dout;
    logic             Valid;
    logic [CNT_W-1:0] Count;

    modport master (
        output Din, En, Ready,
        input  Dout, Valid, Count
    );

    modport slave (
        input  Din, En, Ready,
        output Dout, Valid, Count
    );

endinterface

// File: rtl/exp_encoder325_seq_prio_find32.sv
// Fixed-priority finder: lowest set bit index of a 32-bit vector plus any-set flag.
module prio_find32
    import enc_pkg::*;
(
    input  logic [REQ_W-1:0] vec,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    always_comb begin
        idx = '0;
        any = 1'b0;
        // scan high to low so the lowest set bit is the last one written
        for (int i = REQ_W - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IDX_W'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/exp_encoder325_seq.sv
// Pending-request encoder: captures request bits, presents them lowest index first with
// a valid/ready handshake, and reports how many requests remain pending.
//
// state | meaning
// IDLE  | nothing presented, waiting for a pending bit
// HOLD  | Dout holds a pending index until the consumer accepts it
module exp_encoder325_seq
    import enc_pkg::*;
(
    input logic                 clk,
    input logic                 rst,
    exp_encoder325_seq_if.slave bus
);

    logic [REQ_W-1:0] p_q;
    logic [REQ_W-1:0] p_next;
    logic [REQ_W-1:0] clr;
    logic [REQ_W-1:0] r_vec;
    logic [IDX_W-1:0] p_idx;
    logic [IDX_W-1:0] r_idx;
    logic             p_any;
    logic             r_any;
    logic [IDX_W-1:0] dout_q;
    logic             valid_q;
    logic [CNT_W-1:0] count_q;
    logic             accept;
    state_t           state;

    assign accept = valid_q & bus.Ready;
    assign r_vec  = p_q & ~(REQ_W'(1) << dout_q);

    always_comb begin
        clr = '0;
        if (accept) begin
            clr = REQ_W'(1) << dout_q;
        end
    end

    // new requests are OR'd in after the clear, so a same-cycle re-request survives
    assign p_next = (p_q & ~clr) | (bus.En ? bus.Din : '0);

    prio_find32 u_find_p (
        .vec (p_q),
        .idx (p_idx),
        .any (p_any)
    );

    prio_find32 u_find_r (
        .vec (r_vec),
        .idx (r_idx),
        .any (r_any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            p_q     <= '0;
            count_q <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            state   <= IDLE;
        end else begin
            p_q     <= p_next;
            count_q <= popcount(p_next);
            case (state)
                IDLE: begin
                    if (p_any) begin
                        dout_q  <= p_idx;
                        valid_q <= 1'b1;
                        state   <= HOLD;
                    end else begin
                        valid_q <= 1'b0;
                    end
                end
                HOLD: begin
                    if (bus.Ready) begin
                        if (r_any) begin
                            dout_q  <= r_idx;
                            valid_q <= 1'b1;
                        end else begin
                            valid_q <= 1'b0;
                            state   <= IDLE;
                        end
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.Dout  = dout_q;
    assign bus.Valid = valid_q;
    assign bus.Count = count_q;

endmodule

// File: doc/exp_encoder325_seq.md
EXP_ENCODER325_SEQ -- requirements
Module: exp_encoder325_seq

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port Din, input, 32 bits: one-hot or multi-hot request vector; bit i requests index i.
REQ-004 SHALL have port En, input, 1 bit: when 1, Din bits are captured into the pending set; when 0, Din is ignored.
REQ-005 SHALL have port Ready, input, 1 bit: consumer accepts Dout when Valid=1 and Ready=1 on the same edge.
REQ-006 SHALL have port Dout, output, 5 bits: encoded index of the request being presented.
REQ-007 SHALL have port Valid, output, 1 bit: Dout holds a valid pending index.
REQ-008 SHALL have port Count, output, 6 bits: number of pending requests, range 0..32.

Function
REQ-009 SHALL keep a 32-bit pending register P and update it each edge as P_next = (P & ~clr) | (En ? Din : 0).
- clr is the one-hot of Dout when Valid&Ready, else 0.
- Set wins over clear on the same bit in the same cycle.
REQ-010 SHALL implement FSM states IDLE and HOLD.
- IDLE: Valid=0. If P!=0, load Dout=lowest set index of P, set Valid=1, go to HOLD. Otherwise stay in IDLE.
- HOLD: Valid=1. If Ready=0, Dout and Valid hold and the state stays HOLD.
- HOLD with Ready=1: compute R = P with bit Dout cleared. If R!=0, load Dout=lowest set index of R and stay in HOLD (back-to-back, no bubble). If R==0, set Valid=0 and go to IDLE.
REQ-011 SHALL use fixed priority: index 0 is highest, index 31 is lowest.
REQ-012 SHALL hold Dout stable while Valid=1 and Ready=0, even if a higher-priority request arrives; priority is re-evaluated only when the current index is accepted.
REQ-013 SHALL NOT forward Din to the output combinationally; encode selection reads only the P register.
- Latency is Din captured at edge N, Valid=1 with its index at edge N+1 output of IDLE evaluation, i.e. Valid visible 2 edges after request presentation.
REQ-014 SHALL register Count as popcount(P_next), so Count always equals popcount(P) after each edge.
REQ-015 SHALL merge a re-request of an already-pending bit (no counting or duplication); Count does not increase.
REQ-016 SHALL treat Ready while Valid=0 as having no effect.
REQ-017 SHALL leave P, Dout and Valid unchanged by Din while En=0; presentation and acceptance continue normally.

Reset
REQ-018 SHALL, when rst=1 at an edge, set P=0, state=IDLE, Valid=0, Dout=5'd0 and Count=6'd0, overriding all other inputs.
REQ-019 SHALL discard pending requests and any in-flight presentation on reset mid-operation; Din captured during the reset cycle is dropped.

Structure
REQ-020 SHALL place the following in shared package enc_pkg:
- constants REQ_W=32, IDX_W=5, CNT_W=6;
- typedef enum state_t {IDLE, HOLD}.
REQ-021 SHALL contain one combinational sub-module prio_find32 (32-bit vector in; 5-bit lowest-set index and 1-bit any-set flag out), instantiated twice: once for P, once for R.
REQ-022 SHALL have a target implementation of 120-400 lines of RTL, with no latches and all outputs registered.

Verification
REQ-023 SHALL cover single request: En=1, Din=32'h0000_0010 for 1 cycle, Ready=1 -> Valid=1, Dout=4 for exactly 1 cycle; Count goes 1 then 0.
REQ-024 SHALL cover multi-request drain: Din=32'h8000_0005 for 1 cycle, Ready=1 -> Dout sequence 0, 2, 31 on consecutive cycles with Valid continuous, then Valid=0.
REQ-025 SHALL cover backpressure hold: Din=32'h0000_0100, Ready=0 -> Dout=8 held. Then Din=32'h0000_0001 arrives -> Dout stays 8 and Count=2. Then Ready=1 -> Dout=8, then 0.
REQ-026 SHALL cover set-wins collision: Dout=3 presented, Ready=1 and Din=32'h0000_0008 in the same cycle -> bit 3 remains pending, Dout=3 re-presented next, Count unchanged.
REQ-027 SHALL cover En gating and reset: En=0 with Din=32'hFFFF_FFFF -> Valid=0, Count=0. Then En=1 for 1 cycle -> Count=32. Then rst=1 mid-drain -> next edge Valid=0, Dout=0, Count=0.
